// File: rtl/tdm_demux4_pkg.sv
// ---------------------------------------------------------------------------
// tdm_demux4_pkg
// Shared constants and types for the 4-slot TDM demultiplexer.
//   DEFAULT_WIDTH : default sample / channel data width
//   CH_COUNT      : number of time slots per frame (fixed at 4)
//   state_e       : frame-alignment FSM states (HUNT / RUN)
// ---------------------------------------------------------------------------
package tdm_demux4_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int CH_COUNT      = 4;

  // HUNT waits for a sync-marked sample; RUN walks the slot counter.
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : tdm_demux4_pkg

// File: rtl/tdm_demux4_if.sv
// ---------------------------------------------------------------------------
// tdm_demux4_if
// Bundles the TDM input stream and the per-channel outputs of tdm_demux4.
//   in_data/in_valid/in_sync : incoming time-slot sample, qualifier, slot-0 mark
//   ch0_data..ch3_data       : last captured sample per channel
//   ch_valid                 : one-hot pulse, channel just updated
//   frame_done               : pulse after slot 3 is captured
//   sync_err                 : pulse on sync seen in an unexpected slot
//   locked                   : high while frame alignment is held
// Modports: master drives the stream (source / bench), slave is the demux.
// ---------------------------------------------------------------------------
interface tdm_demux4_if #(
  parameter int WIDTH = tdm_demux4_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] ch0_data;
  logic [WIDTH-1:0] ch1_data;
  logic [WIDTH-1:0] ch2_data;
  logic [WIDTH-1:0] ch3_data;
  logic [3:0]       ch_valid;
  logic             frame_done;
  logic             sync_err;
  logic             locked;

  modport master (
    output in_data, in_valid, in_sync,
    input  ch0_data, ch1_data, ch2_data, ch3_data,
    input  ch_valid, frame_done, sync_err, locked
  );

  modport slave (
    input  in_data, in_valid, in_sync,
    output ch0_data, ch1_data, ch2_data, ch3_data,
    output ch_valid, frame_done, sync_err, locked
  );

endinterface : tdm_demux4_if

// File: rtl/tdm_demux4_slot_dmux4.sv
// ---------------------------------------------------------------------------
// slot_dmux4
// Decodes a 2-bit slot select into four one-hot channel enables.
//   sel_i : slot number 0..3
//   en_i  : global enable; all outputs low when deasserted
//   en_o  : one-hot enables, bit n set when en_i and sel_i == n
// ---------------------------------------------------------------------------
module slot_dmux4 (
  input  logic [1:0] sel_i,
  input  logic       en_i,
  output logic [3:0] en_o
);

  // Purely combinational decode; at most one bit can ever be set.
  always_comb begin
    en_o = 4'b0000;
    if (en_i) begin
      en_o[sel_i] = 1'b1;
    end
  end

endmodule : slot_dmux4

// File: rtl/tdm_demux4.sv
// ---------------------------------------------------------------------------
// tdm_demux4
// Splits a 4-slot TDM sample stream into four registered channels.
//   clk   : single clock, all state changes on its rising edge
//   rst_n : synchronous active-low reset
//   bus   : tdm_demux4_if.slave (input stream + channel outputs)
// In HUNT only a sync-marked sample is accepted (as slot 0). In RUN every
// valid sample goes to the current slot; a sync in a non-zero slot realigns
// the frame to slot 0 and raises sync_err. All outputs are registered.
// ---------------------------------------------------------------------------
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int NUM_CH = CH_COUNT
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux4_if.slave bus
);

  state_e           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] chData_q [NUM_CH];
  logic [3:0]       chValid_q;
  logic             frameDone_q;
  logic             syncErr_q;

  logic             accept;
  logic             resync;
  logic [1:0]       sel;
  logic [3:0]       chEn;

  // A sample is taken when valid and either already aligned or sync-marked.
  // A sync always forces slot 0, which also covers the HUNT entry case
  // (slot is 0 there anyway). Slot and state only move on accepted samples,
  // so in_valid low freezes everything.
  always_comb begin
    accept  = bus.in_valid && ((state_q == RUN) || bus.in_sync);
    sel     = bus.in_sync ? 2'd0 : slot_q;
    resync  = bus.in_valid && bus.in_sync && (state_q == RUN) && (slot_q != 2'd0);
    slot_d  = slot_q;
    state_d = state_q;
    if (accept) begin
      slot_d  = sel + 2'd1;
      state_d = RUN;
    end
  end

  slot_dmux4 u_slot_dmux4 (
    .sel_i (sel),
    .en_i  (accept),
    .en_o  (chEn)
  );

  // State, slot counter, channel registers and the pulse outputs. The pulses
  // are simply the registered enables, so they last exactly one cycle and
  // frame_done lines up with the slot-3 capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= 2'd0;
      chValid_q   <= 4'b0000;
      frameDone_q <= 1'b0;
      syncErr_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        chData_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      chValid_q   <= chEn;
      frameDone_q <= chEn[3];
      syncErr_q   <= resync;
      for (int i = 0; i < NUM_CH; i++) begin
        if (chEn[i]) begin
          chData_q[i] <= bus.in_data;
        end
      end
    end
  end

  assign bus.ch0_data   = chData_q[0];
  assign bus.ch1_data   = chData_q[1];
  assign bus.ch2_data   = chData_q[2];
  assign bus.ch3_data   = chData_q[3];
  assign bus.ch_valid   = chValid_q;
  assign bus.frame_done = frameDone_q;
  assign bus.sync_err   = syncErr_q;
  assign bus.locked     = (state_q == RUN);

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux4
// Directed stimulus for tdm_demux4. Every accepted sample pushes its
// hand-computed expected pulse into a queue; a monitor pops one entry
// whenever the DUT shows any pulse and compares it.
// ---------------------------------------------------------------------------
module tb_tdm_demux4;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  chValid;
    logic        frameDone;
    logic        syncErr;
    logic [15:0] data;
  } exp_t;

  exp_t expQ[$];

  tdm_demux4_if #(.WIDTH(16)) bus ();

  tdm_demux4 #(.WIDTH(16), .NUM_CH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point used by both the monitor and the main flow.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One cycle of stimulus: inputs change on the falling edge, the DUT samples
  // on the next rising edge. A nonzero expCh means a pulse is expected.
  task automatic applyStimulus(input logic [15:0] d, input logic v, input logic s,
                               input logic [3:0] expCh, input logic expFd, input logic expErr);
    exp_t e;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = v;
    bus.in_sync  = s;
    if (expCh != 4'b0000) begin
      e.chValid   = expCh;
      e.frameDone = expFd;
      e.syncErr   = expErr;
      e.data      = d;
      expQ.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    end
  endtask

  task automatic checkChannels(input string tag, input logic [15:0] c0, input logic [15:0] c1,
                               input logic [15:0] c2, input logic [15:0] c3, input logic lk);
    checkOutput({tag, "_ch0"}, 32'(bus.ch0_data), 32'(c0));
    checkOutput({tag, "_ch1"}, 32'(bus.ch1_data), 32'(c1));
    checkOutput({tag, "_ch2"}, 32'(bus.ch2_data), 32'(c2));
    checkOutput({tag, "_ch3"}, 32'(bus.ch3_data), 32'(c3));
    checkOutput({tag, "_locked"}, 32'(bus.locked), 32'(lk));
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
  endtask

  // Monitor: just after each rising edge, any pulse must match the oldest
  // expected entry; a pulse with nothing queued is an error on its own.
  initial begin
    exp_t e;
    logic [15:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ch_valid != 4'b0000 || bus.frame_done || bus.sync_err) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pulse actual=%b/%b/%b required=none",
                   bus.ch_valid, bus.frame_done, bus.sync_err);
        end else begin
          e = expQ.pop_front();
          case (e.chValid)
            4'b0010: got = bus.ch1_data;
            4'b0100: got = bus.ch2_data;
            4'b1000: got = bus.ch3_data;
            default: got = bus.ch0_data;
          endcase
          checkOutput("ch_valid", 32'(bus.ch_valid), 32'(e.chValid));
          checkOutput("frame_done", 32'(bus.frame_done), 32'(e.frameDone));
          checkOutput("sync_err", 32'(bus.sync_err), 32'(e.syncErr));
          checkOutput("ch_data", 32'(got), 32'(e.data));
          checkOutput("locked_on_pulse", 32'(bus.locked), 32'd1);
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_data  = 16'h0000;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    repeat (2) @(negedge clk);
    checkChannels("reset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    checkOutput("reset_ch_valid", 32'(bus.ch_valid), 32'd0);
    rst_n = 1'b1;

    $display("[TB] scenario 1: unsynced samples in HUNT");
    applyStimulus(16'h1111, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(16'h2222, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(1);
    checkChannels("hunt", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    $display("[TB] scenario 2: aligned frame");
    applyStimulus(16'h000A, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(16'h000B, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    applyStimulus(16'h000C, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    applyStimulus(16'h000D, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0);
    idle(1);
    checkChannels("frame1", 16'h000A, 16'h000B, 16'h000C, 16'h000D, 1'b1);
    checkDrained("frame1");

    $display("[TB] scenario 3: frame with stall gap");
    applyStimulus(16'h001A, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(16'h001B, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    idle(3);
    checkChannels("gap", 16'h001A, 16'h001B, 16'h000C, 16'h000D, 1'b1);
    applyStimulus(16'h001C, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    applyStimulus(16'h001D, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0);
    idle(1);
    checkChannels("frame2", 16'h001A, 16'h001B, 16'h001C, 16'h001D, 1'b1);
    checkDrained("frame2");

    $display("[TB] scenario 4: resync in slot 2");
    applyStimulus(16'h0031, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(16'h0032, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    applyStimulus(16'h00EE, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    applyStimulus(16'h0033, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    applyStimulus(16'h0034, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    applyStimulus(16'h0035, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0);
    idle(1);
    checkChannels("resync", 16'h00EE, 16'h0033, 16'h0034, 16'h0035, 1'b1);
    checkDrained("resync");

    $display("[TB] scenario 5: back-to-back frames, second unsynced");
    applyStimulus(16'h0041, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(16'h0042, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    applyStimulus(16'h0043, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    applyStimulus(16'h0044, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0);
    applyStimulus(16'h0051, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
    applyStimulus(16'h0052, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    applyStimulus(16'h0053, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    applyStimulus(16'h0054, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0);
    idle(1);
    checkChannels("wrap", 16'h0051, 16'h0052, 16'h0053, 16'h0054, 1'b1);
    checkDrained("wrap");

    $display("[TB] scenario 6: reset mid-frame");
    applyStimulus(16'h0061, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    applyStimulus(16'h0062, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0);
    applyStimulus(16'h0063, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0);
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_data  = 16'h0099;
    bus.in_valid = 1'b1;
    bus.in_sync  = 1'b1;
    @(negedge clk);
    checkChannels("midreset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    checkOutput("midreset_ch_valid", 32'(bus.ch_valid), 32'd0);
    checkOutput("midreset_frame_done", 32'(bus.frame_done), 32'd0);
    checkOutput("midreset_sync_err", 32'(bus.sync_err), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    applyStimulus(16'h0077, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    idle(1);
    checkChannels("postreset", 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    applyStimulus(16'h0081, 1'b1, 1'b1, 4'b0001, 1'b0, 1'b0);
    idle(2);
    checkChannels("relock", 16'h0081, 16'h0, 16'h0, 16'h0, 1'b1);
    checkDrained("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tdm_demux4

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of the input sample and of each channel.
REQ-002 The block SHALL have parameter NUM_CH, fixed at 4, giving the number of time slots per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port in_data, input, WIDTH bits: the current time-slot sample.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data holds a sample this cycle.
REQ-007 The block SHALL have port in_sync, input, 1 bit: qualified by in_valid, it marks the current sample as slot 0.
REQ-008 The block SHALL have ports ch0_data to ch3_data, output, WIDTH bits each: registered last sample per channel.
REQ-009 The block SHALL have port ch_valid, output, 4 bits: one-cycle pulse, bit n high when chn_data has just been updated.
REQ-010 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse after slot 3 is captured.
REQ-011 The block SHALL have port sync_err, output, 1 bit: one-cycle pulse on a sync received in an unexpected slot.
REQ-012 The block SHALL have port locked, output, 1 bit: high while in state RUN.

Function
REQ-013 The FSM SHALL have two states: HUNT and RUN, plus a 2-bit slot counter.
- HUNT: samples without in_sync are discarded (no output change); in_valid and in_sync -> capture to ch0, slot=1, go to RUN.
- RUN: each in_valid sample is captured to ch[slot]; slot increments mod 4 (3 -> 0 wrap).
REQ-014 Capture latency SHALL be one cycle: sample accepted at edge k -> chn_data and ch_valid[n] visible after edge k.
REQ-015 chn_data SHALL hold its value until that channel's next capture; ch_valid bits SHALL be zero in any cycle without capture.
REQ-016 in_valid low SHALL stall the block: slot, state and all data hold; no pulses.
REQ-017 RUN, in_valid and in_sync with slot==0 SHALL be a normal slot-0 capture with no error.
REQ-018 RUN, in_valid and in_sync with slot!=0 SHALL resynchronise in the same cycle.
- The sample is captured to ch0 and slot becomes 1.
- sync_err pulses.
- frame_done does not pulse.
REQ-019 RUN, in_valid with in_sync low and slot==0 SHALL be accepted as slot 0 (free-running frames; sync is optional after lock).
REQ-020 frame_done SHALL pulse in the same cycle as ch_valid[3].
REQ-021 At most one ch_valid bit SHALL be high in any cycle.

Reset
REQ-022 With rst_n low at a rising clk edge, the block SHALL enter the following reset state, overriding any in_valid in that cycle:
- state HUNT, slot 0;
- all chn_data set to 0;
- ch_valid, frame_done, sync_err and locked set to 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; after release, the block SHALL require in_sync before any capture.

Structure
REQ-024 WIDTH, NUM_CH and the HUNT/RUN state encodings SHALL be defined in the shared constants include file.
REQ-025 Slot-to-channel enable decoding SHALL be a sub-module slot_dmux4: 2-bit sel plus an enable in, 4 one-hot enables out.
REQ-026 The four channel registers SHALL be enabled by slot_dmux4 outputs.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
- Reset, then valid samples 0x1111 and 0x2222 with sync=0 -> no ch_valid, locked=0, all chn_data=0.
- Sync+0x000A, then 0x000B, 0x000C, 0x000D consecutive -> ch_valid 0001, 0010, 0100, 1000 on successive cycles; ch0..3 = A, B, C, D; frame_done with the last; locked=1.
- Same frame with in_valid low for 3 cycles between B and C -> identical data; no pulses during the gap; slot preserved.
- In RUN after slot 1 is captured, sync+0x00EE -> sync_err=1; ch0=0x00EE; the next sample lands in ch1.
- Two frames back-to-back without sync on the second -> wrap 3 -> 0; second frame captured correctly; frame_done twice.
- rst_n low after slot 2 -> all outputs 0, HUNT; a following non-sync sample is ignored.
